// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers host payload bytes and frames them as header,
// payload and even-XOR parity onto the router packet_valid/datain pins.
// Ports: clk, resetn (async, active-low); host side wr_en/wr_data,
// start/dest/len; router side busy_in, packet_valid, data_out;
// status tx_busy, done, start_err, wr_ovf, fifo_count, fifo_full.
// Optional: ROUTER_PKT_TX_ERR_INJECT_EN adds inject_err (flips parity bit 0).
module router_pkt_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          start,
  input  logic [1:0]                    dest,
  input  logic [3:0]                    len,
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
  input  logic                          inject_err,
`endif
  input  logic                          busy_in,
  output logic                          packet_valid,
  output logic [7:0]                    data_out,
  output logic                          tx_busy,
  output logic                          done,
  output logic                          start_err,
  output logic                          wr_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    HDR,
    PAY,
    PAR,
    GAP
  } state_t;

  state_t state;
  state_t nxt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  logic [3:0]    len_q;
  logic [1:0]    dest_q;
  logic [3:0]    cnt;
  logic [7:0]    par_q;
  logic [GW-1:0] gap_cnt;
  logic          req_ok;
  logic          inj_q;
  logic [7:0]    hdr;

  assign push      = wr_en && !fifo_full;
  assign pop       = (state == PAY);
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign tx_busy   = (state != IDLE);
  assign hdr       = {2'b00, len_q, dest_q};

  // The count check guarantees PAY can never underflow the buffer.
  assign req_ok = (len != 4'd0)
               && (dest != 2'd3)
               && (fifo_count >= CW'(len));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start && req_ok) nxt = WAIT;
      WAIT: if (!busy_in) nxt = HDR;
      HDR:  nxt = PAY;
      PAY:  if (cnt == 4'd1) nxt = PAR;
      PAR:  nxt = GAP;
      GAP:  if (gap_cnt == GW'(GAP_CYCLES - 1)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      wr_ovf     <= 1'b0;
    end else begin
      wr_ovf <= wr_en && fifo_full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Output bytes are registered from the current state, so each
  // state's byte appears on the pins one cycle after entering it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      packet_valid <= 1'b0;
      data_out     <= '0;
      done         <= 1'b0;
      start_err    <= 1'b0;
      len_q        <= '0;
      dest_q       <= '0;
      cnt          <= '0;
      par_q        <= '0;
      gap_cnt      <= '0;
    end else begin
      start_err    <= (state == IDLE) && start && !req_ok;
      done         <= (state == GAP) && (gap_cnt == '0);
      packet_valid <= 1'b0;
      data_out     <= '0;
      gap_cnt      <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      unique case (state)
        IDLE: begin
          if (start && req_ok) begin
            len_q  <= len;
            dest_q <= dest;
          end
        end
        HDR: begin
          packet_valid <= 1'b1;
          data_out     <= hdr;
          par_q        <= hdr;
          cnt          <= len_q;
        end
        PAY: begin
          packet_valid <= 1'b1;
          data_out     <= mem[rd_ptr];
          par_q        <= par_q ^ mem[rd_ptr];
          cnt          <= cnt - 1'b1;
        end
        PAR: begin
          packet_valid <= 1'b1;
          data_out     <= par_q ^ {7'd0, inj_q};
        end
        default: ;
      endcase
    end
  end

`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            inj_q <= 1'b0;
    else if (state == IDLE && start && req_ok) inj_q <= inject_err;
  end
`else
  assign inj_q = 1'b0;
`endif

endmodule
